clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Multi-channel programmable clock-enable/divided-clock generator driven from the board reference clock. It replaces fixed single-ratio dividers in the DDS/FPGA timing path. It produces CHANNELS independent divided outputs, each with a runtime-programmable period and high time. New settings are loaded through a valid/ready handshake and take effect glitch-free at a period boundary. Outputs are registered and intended as clock enables or low-speed clocks for downstream DDS/receiver logic.

## Interface
- CHANNELS, 2, number of independent divider channels (1..16)
- CNT_W, 8, counter/config width; max period 2^CNT_W-1
- RESET_DIV, 5, period (ref cycles) loaded into every channel at reset
- RESET_HIGH, 2, high time (ref cycles) loaded at reset
- ref_clock  in  1  reference clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_chan  in  CH_W = max(1,clog2(CHANNELS))  target channel
- cfg_div  in  CNT_W  requested period
- cfg_high  in  CNT_W  requested high time
- enable  in  CHANNELS  per-channel run enable
- sync_in  in  1  single-cycle realign pulse (see Configuration)
- clk_out  out  CHANNELS  registered divided output
- tick  out  CHANNELS  registered one-cycle pulse, first cycle of each period

## Operation
- Per channel: counter cnt, active div_a/high_a, shadow div_s/high_s, pending flag.
- Reset (async): cnt=0, div_a=RESET_DIV, high_a=RESET_HIGH, pending=0, clk_out=0, tick=0.
- Enabled edge: clk_out <= (cnt < high_a); tick <= (cnt==0); cnt <= (cnt==div_a-1) ? 0 : cnt+1.
- Disabled edge: cnt <= 0, clk_out <= 0, tick <= 0. Re-enable starts a fresh period at cnt=0.
- Clamping on capture: div<2 -> 2; high==0 -> 1; high>=div -> div-1. The output therefore always toggles.
- cfg_ready = !pending[cfg_chan] (combinational). For cfg_chan>=CHANNELS, cfg_ready=1 and the write is dropped.
- Accept (cfg_valid & cfg_ready): store clamped values in shadow and set pending.
- Apply: on an enabled edge where cnt==div_a-1, or on any edge where enable=0, copy shadow to active and clear pending. The new period begins at the next cnt==0.
- Accept and apply never coincide for one channel: pending gates ready.

## Timing
- clk_out/tick lag the counter state by one cycle (registered).
- After reset release with defaults (div 5, high 2), enabled: clk_out = 1,1,0,0,0 repeating from the first edge; tick high on edges 1, 6, 11, ...
- Config latency: accept at edge A; applied at the next period end of that channel (≤ div_a cycles later). The first new-ratio period starts the edge after the apply edge.
- cfg_ready for a channel drops the cycle after accept and returns high the cycle after apply.
- Reset asserted mid-period: outputs go to 0 immediately (async). Pending writes are discarded.

## Configuration
- CLKDIV_SYNC_EN defined: an edge with sync_in=1 does the following on every enabled channel:
  - applies any pending config first;
  - forces a period start: clk_out <= 1, tick <= 1, cnt <= 1.
- If sync_in coincides with a config accept, the accept is captured and applies at the next natural boundary.
- CLKDIV_SYNC_EN undefined: the sync_in port is present but ignored. No realignment logic is synthesised.

## Test plan
- Reset, enable=all ones, defaults -> each clk_out = 11000 repeating, tick every 5 cycles, all channels in phase.
- Write ch1 div=4 high=1 mid-period -> ch1 finishes its current 5-cycle period, then 1000 repeating. ch0 unchanged. cfg_ready for ch1 is low until apply.
- Write div=1 high=0, then div=3 high=7 -> clamped to 2/1 (10) and 3/2 (110) respectively.
- Disable ch0 for 7 cycles, then re-enable -> clk_out=0 while disabled. On re-enable, the pattern restarts with 11000 from cnt=0.
- With CLKDIV_SYNC_EN: ch0 div=5, ch1 div=3 drifting, pulse sync_in -> both clk_out=1 and tick=1 on the next cycle, then phase-aligned patterns.
- Assert reset_n low mid-period with a pending write -> outputs 0 immediately. After release, the default ratio is used and the pending write is lost.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable divider. Each channel has shadow settings that are applied at a period boundary.
// Defining CLKDIV_SYNC_EN enables sync_in realignment; when it is undefined, sync_in is ignored.
module clock_divider_multi #(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 8,
  parameter int RESET_DIV  = 5,
  parameter int RESET_HIGH = 2,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                ref_clock,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_in,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_INIT   = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] HIGH_INIT  = CNT_W'(RESET_HIGH);

  logic [CHANNELS-1:0] pending;
  logic [CNT_W-1:0]    div_clamped;
  logic [CNT_W-1:0]    high_clamped;

  // Clamp so that every accepted setting still produces a toggling output.
  always_comb begin
    div_clamped  = (cfg_div < TWO) ? TWO : cfg_div;
    high_clamped = (cfg_high == '0) ? ONE : cfg_high;
    if (high_clamped >= div_clamped) begin
      high_clamped = div_clamped - ONE;
    end
  end

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CH_W'(i)) begin
        cfg_ready = !pending[i];
      end
    end
  end

`ifndef CLKDIV_SYNC_EN
  logic sync_unused;
  assign sync_unused = sync_in;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_a_reg;
    logic [CNT_W-1:0] high_a_reg;
    logic [CNT_W-1:0] div_s_reg;
    logic [CNT_W-1:0] high_s_reg;
    logic             pending_reg;
    logic             clk_reg;
    logic             tick_reg;
    logic             accept;
    logic             period_end;
    logic             force_start;
    logic             apply;

    assign accept     = cfg_valid && !pending_reg && (cfg_chan == CH_W'(gi));
    assign period_end = enable[gi] && (cnt_reg == div_a_reg - ONE);
`ifdef CLKDIV_SYNC_EN
    assign force_start = sync_in && enable[gi];
`else
    assign force_start = 1'b0;
`endif
    // A disabled channel has no period in progress, so it may switch ratio at any time.
    assign apply = pending_reg && (!enable[gi] || period_end || force_start);

    always_ff @(posedge ref_clock or negedge reset_n) begin
      if (!reset_n) begin
        div_a_reg   <= DIV_INIT;
        high_a_reg  <= HIGH_INIT;
        div_s_reg   <= DIV_INIT;
        high_s_reg  <= HIGH_INIT;
        pending_reg <= 1'b0;
      end else if (apply) begin
        div_a_reg   <= div_s_reg;
        high_a_reg  <= high_s_reg;
        pending_reg <= 1'b0;
      end else if (accept) begin
        div_s_reg   <= div_clamped;
        high_s_reg  <= high_clamped;
        pending_reg <= 1'b1;
      end
    end

    // The realign edge acts as the cnt==0 edge of a fresh period.
    always_ff @(posedge ref_clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg  <= '0;
        clk_reg  <= 1'b0;
        tick_reg <= 1'b0;
      end else if (!enable[gi]) begin
        cnt_reg  <= '0;
        clk_reg  <= 1'b0;
        tick_reg <= 1'b0;
      end else if (force_start) begin
        cnt_reg  <= ONE;
        clk_reg  <= 1'b1;
        tick_reg <= 1'b1;
      end else begin
        clk_reg  <= (cnt_reg < high_a_reg);
        tick_reg <= (cnt_reg == '0);
        cnt_reg  <= period_end ? '0 : cnt_reg + ONE;
      end
    end

    assign pending[gi] = pending_reg;
    assign clk_out[gi] = clk_reg;
    assign tick[gi]    = tick_reg;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with CHANNELS=2 and CNT_W=8.
// Expected patterns are written MSB-first with one bit per ref_clock edge.
module tb_clock_divider_multi;

  logic       ref_clock;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_chan;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic [1:0] enable;
  logic       sync_in;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int checks   = 0;
  int failures = 0;

  clock_divider_multi #(
    .CHANNELS  (2),
    .CNT_W     (8),
    .RESET_DIV (5),
    .RESET_HIGH(2)
  ) dut (
    .ref_clock(ref_clock),
    .reset_n  (reset_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .enable   (enable),
    .sync_in  (sync_in),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial begin
    ref_clock = 1'b0;
    forever #5 ref_clock = ~ref_clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample both output vectors on the falling edge.
  task automatic edge_check(input string tag, input logic [1:0] exp_clk, input logic [1:0] exp_tick);
    @(posedge ref_clock);
    @(negedge ref_clock);
    check_val({tag, "_clk"}, 32'(clk_out), 32'(exp_clk));
    check_val({tag, "_tick"}, 32'(tick), 32'(exp_tick));
  endtask

  task automatic run_seq(input string tag, input int n, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] t0, input logic [31:0] t1);
    for (int k = 0; k < n; k++) begin
      edge_check($sformatf("%s%0d", tag, k), {c1[n-1-k], c0[n-1-k]}, {t1[n-1-k], t0[n-1-k]});
    end
  endtask

  task automatic cfg_drive(input logic [0:0] chan, input logic [7:0] div, input logic [7:0] high);
    cfg_valid = 1'b1;
    cfg_chan  = chan;
    cfg_div   = div;
    cfg_high  = high;
    $display("cfg write ch%0d div=%0d high=%0d", chan, div, high);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_high  = '0;
    enable    = 2'b11;
    sync_in   = 1'b0;
    @(negedge ref_clock);
    @(negedge ref_clock);
    check_val("rst_clk", 32'(clk_out), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_ready", 32'(cfg_ready), 32'd1);
    reset_n = 1'b1;

    // Defaults 5/2 on both channels, in phase (edges 1..12)
    run_seq("dflt", 12, 12'b110001100011, 12'b110001100011, 12'b100001000010, 12'b100001000010);

    // ch1 -> 4/1 while ch1 is at cnt=2
    cfg_chan = 1'b1;
    check_val("rdy_idle", 32'(cfg_ready), 32'd1);
    cfg_drive(1'b1, 8'd4, 8'd1);
    edge_check("acc13", 2'b00, 2'b00);
    cfg_valid = 1'b0;
    check_val("rdy_acc13", 32'(cfg_ready), 32'd0);
    edge_check("wait14", 2'b00, 2'b00);
    check_val("rdy_wait14", 32'(cfg_ready), 32'd0);
    edge_check("apply15", 2'b00, 2'b00);
    check_val("rdy_apply15", 32'(cfg_ready), 32'd1);
    run_seq("div4_", 12, 12'b110001100011, 12'b100010001000, 12'b100001000010, 12'b100010001000);

    // ch1 div=1 high=0 is clamped to 2/1
    cfg_drive(1'b1, 8'd1, 8'd0);
    edge_check("acc28", 2'b10, 2'b10);
    cfg_valid = 1'b0;
    run_seq("clampA", 9, 9'b001100011, 9'b000101010, 9'b001000010, 9'b000101010);

    // ch1 div=3 high=7 is clamped to 3/2
    cfg_drive(1'b1, 8'd3, 8'd7);
    edge_check("acc38", 2'b10, 2'b10);
    cfg_valid = 1'b0;
    run_seq("clampB", 9, 9'b001100011, 9'b011011011, 9'b001000010, 9'b010010010);

    // ch0 disabled for 7 edges, then restarts from cnt=0
    enable = 2'b10;
    run_seq("dis", 7, 7'b0000000, 7'b0110110, 7'b0000000, 7'b0100100);
    enable = 2'b11;
    run_seq("reen", 10, 10'b1100011000, 10'b1101101101, 10'b1000010000, 10'b1001001001);

    // sync_in pulse while ch0 is at cnt=0 and ch1 is at cnt=1
    sync_in = 1'b1;
`ifdef CLKDIV_SYNC_EN
    edge_check("sync65", 2'b11, 2'b11);
    sync_in = 1'b0;
    run_seq("sync", 5, 5'b10001, 5'b10110, 5'b00001, 5'b00100);
`else
    edge_check("sync65", 2'b11, 2'b01);
    sync_in = 1'b0;
    run_seq("nosync", 5, 5'b10001, 5'b01101, 5'b00001, 5'b01001);
`endif

    // A fresh reset, followed by reset mid-period with a pending ch0 write
    reset_n = 1'b0;
    @(negedge ref_clock);
    reset_n = 1'b1;
    edge_check("r2e1", 2'b11, 2'b11);
    cfg_drive(1'b0, 8'd3, 8'd1);
    edge_check("r2e2", 2'b11, 2'b00);
    cfg_valid = 1'b0;
    cfg_chan  = 1'b0;
    check_val("rdy_pend0", 32'(cfg_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_val("async_clk", 32'(clk_out), 32'd0);
    check_val("async_tick", 32'(tick), 32'd0);
    check_val("async_ready", 32'(cfg_ready), 32'd1);
    @(negedge ref_clock);
    reset_n = 1'b1;
    run_seq("post", 10, 10'b1100011000, 10'b1100011000, 10'b1000010000, 10'b1000010000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
